// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared state encoding, default sizes and slice helper for the register bus reader
package reg_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREG  = 4;
   localparam int DEF_SEL_W = 2;

   function automatic logic [DEF_WIDTH-1:0] get_slice(
      input logic [DEF_NREG*DEF_WIDTH-1:0] bus,
      input logic [DEF_SEL_W-1:0]          idx
   );
      return bus[idx*DEF_WIDTH +: DEF_WIDTH];
   endfunction

endpackage

// File: rtl/reg_bus_if.sv
// rtl/reg_bus_if.sv - burst command and output bus handshake bundle; BUS_PARITY_EN adds bus_parity
interface reg_bus_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
);
   logic             rd_start;
   logic [SEL_W-1:0] rd_addr;
   logic [SEL_W:0]   rd_count;
   logic             bus_ready;
   logic [WIDTH-1:0] BusOut;
   logic             bus_valid;
   logic             busy;
   logic             done;
`ifdef BUS_PARITY_EN
   logic             bus_parity;

   modport master (
      input  rd_start, rd_addr, rd_count, bus_ready,
      output BusOut, bus_valid, busy, done, bus_parity
   );
   modport slave (
      output rd_start, rd_addr, rd_count, bus_ready,
      input  BusOut, bus_valid, busy, done, bus_parity
   );
`else
   modport master (
      input  rd_start, rd_addr, rd_count, bus_ready,
      output BusOut, bus_valid, busy, done
   );
   modport slave (
      output rd_start, rd_addr, rd_count, bus_ready,
      input  BusOut, bus_valid, busy, done
   );
`endif
endinterface

// File: rtl/reg_bus_mux.sv
// rtl/reg_bus_mux.sv - combinational NREG:1 selector over the flattened register bank
module reg_bus_mux #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   parameter int SEL_W = 2
) (
   input  logic [NREG*WIDTH-1:0] reg_data,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      data
);
   assign data = reg_data[sel*WIDTH +: WIDTH];
endmodule

// File: rtl/reg_bus_reader.sv
// rtl/reg_bus_reader.sv - bursts consecutive register values onto a valid/ready bus, wrapping the bank
// Optional BUS_PARITY_EN adds a registered even-parity bit alongside BusOut.
module reg_bus_reader
   import reg_bus_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREG  = DEF_NREG,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic                  Clk,
   input  logic                  rstN,
   input  logic [NREG*WIDTH-1:0] reg_data,
   reg_bus_if.master             bus
);
   localparam logic [SEL_W:0]   CNT_MAX = (SEL_W+1)'(NREG);
   localparam logic [SEL_W:0]   CNT_ONE = (SEL_W+1)'(1);
   localparam logic [SEL_W-1:0] ADR_ONE = SEL_W'(1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] addr_q, addr_d, sel;
   logic [SEL_W:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d, mux_out;
   logic             valid_q, valid_d;
   logic             done_q, done_d;

   // One selector serves both the first load (rd_addr) and the next-beat preload (addr+1).
   reg_bus_mux #(.WIDTH(WIDTH), .NREG(NREG), .SEL_W(SEL_W)) u_mux (
      .reg_data (reg_data),
      .sel      (sel),
      .data     (mux_out)
   );

   always_ff @(posedge Clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      sel     = addr_q + ADR_ONE;
      case (state_q)
         IDLE: begin
            sel = bus.rd_addr;
            if (bus.rd_start && (bus.rd_count != '0)) begin
               addr_d  = bus.rd_addr;
               cnt_d   = (bus.rd_count > CNT_MAX) ? CNT_MAX : bus.rd_count;
               data_d  = mux_out;
               valid_d = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (valid_q && bus.bus_ready) begin
               if (cnt_q > CNT_ONE) begin
                  addr_d = addr_q + ADR_ONE;
                  cnt_d  = cnt_q - CNT_ONE;
                  data_d = mux_out;
               end else begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.BusOut    = data_q;
   assign bus.bus_valid = valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

`ifdef BUS_PARITY_EN
   logic parity_q;

   always_ff @(posedge Clk or negedge rstN) begin
      if (!rstN) parity_q <= 1'b0;
      else       parity_q <= ^data_d;
   end

   assign bus.bus_parity = parity_q;
`endif
endmodule

// File: tb/tb_reg_bus_reader.sv
// tb/tb_reg_bus_reader.sv - vector table, hand sequences and random bursts against a byte-rotation model
module tb_reg_bus_reader;

   logic        Clk = 1'b0;
   logic        rstN = 1'b0;
   logic [31:0] reg_data = '0;
   int          tests = 0;
   int          fails = 0;

   reg_bus_if #(.WIDTH(8), .SEL_W(2)) bus ();

   reg_bus_reader #(.WIDTH(8), .NREG(4), .SEL_W(2)) dut (
      .Clk      (Clk),
      .rstN     (rstN),
      .reg_data (reg_data),
      .bus      (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]  addr;
      logic [2:0]  cnt;
      logic [31:0] data;
      logic [15:0] pat;
      bit          poke;
      int          n;
      logic [31:0] beats;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_beat(input logic [31:0] d, input int a, input int k);
      int r;
      r = (a + k) % 4;
      return d[r*8 +: 8];
   endfunction

   task automatic run_burst(input string tag, input logic [1:0] addr, input logic [2:0] cnt,
                            input logic [31:0] data, input logic [15:0] pat, input bit poke,
                            input int n, input logic [31:0] beats);
      int         c;
      int         idx;
      logic [7:0] exp_b;
      reg_data      = data;
      bus.rd_addr   = addr;
      bus.rd_count  = cnt;
      bus.rd_start  = 1'b1;
      bus.bus_ready = 1'b0;
      @(negedge Clk);
      bus.rd_start = 1'b0;
      if (n == 0) begin
         repeat (2) begin
            check({tag, " noop valid"}, 32'(bus.bus_valid), 0);
            check({tag, " noop busy"}, 32'(bus.busy), 0);
            check({tag, " noop done"}, 32'(bus.done), 0);
            @(negedge Clk);
         end
         return;
      end
      c = 0;
      idx = 0;
      while (idx < n && c < 64) begin
         exp_b = beats[idx*8 +: 8];
         check({tag, " valid"}, 32'(bus.bus_valid), 1);
         check({tag, " busy"}, 32'(bus.busy), 1);
         check({tag, " done early"}, 32'(bus.done), 0);
         check({tag, " beat"}, 32'(bus.BusOut), 32'(exp_b));
`ifdef BUS_PARITY_EN
         check({tag, " parity"}, 32'(bus.bus_parity), 32'(^exp_b));
`endif
         bus.bus_ready = (c < 16) ? pat[c] : 1'b1;
         bus.rd_start  = poke && (c == 0);
         bus.rd_addr   = addr + 2'd2;
         bus.rd_count  = 3'd1;
         if (bus.bus_ready) idx++;
         c++;
         @(negedge Clk);
      end
      bus.rd_start  = 1'b0;
      bus.bus_ready = 1'($urandom_range(0, 1));
      if (idx < n) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: got %0d beats expected %0d", tag, idx, n);
      end
      check({tag, " end valid"}, 32'(bus.bus_valid), 0);
      check({tag, " end done"}, 32'(bus.done), 1);
      check({tag, " end busy"}, 32'(bus.busy), 1);
      @(negedge Clk);
      check({tag, " idle done"}, 32'(bus.done), 0);
      check({tag, " idle busy"}, 32'(bus.busy), 0);
      check({tag, " idle valid"}, 32'(bus.bus_valid), 0);
      check({tag, " last held"}, 32'(bus.BusOut), 32'(beats[(n-1)*8 +: 8]));
      bus.bus_ready = 1'b0;
   endtask

   initial begin
      logic [1:0]  r_addr;
      logic [2:0]  r_cnt;
      logic [31:0] r_data;
      logic [31:0] r_beats;
      int          r_n;

      vecs[0] = '{2'd1, 3'd2, 32'h44332211, 16'hFFFF, 1'b0, 2, 32'h00003322};
      vecs[1] = '{2'd3, 3'd3, 32'h44332211, 16'hFFFD, 1'b0, 3, 32'h00221144};
      vecs[2] = '{2'd2, 3'd0, 32'h44332211, 16'hFFFF, 1'b0, 0, 32'h00000000};
      vecs[3] = '{2'd2, 3'd7, 32'h44332211, 16'hFFFF, 1'b0, 4, 32'h22114433};
      vecs[4] = '{2'd0, 3'd3, 32'hDDCCBBAA, 16'hFFFF, 1'b1, 3, 32'h00CCBBAA};
      vecs[5] = '{2'd1, 3'd4, 32'h04030201, 16'h5555, 1'b0, 4, 32'h01040302};
      vecs[6] = '{2'd2, 3'd1, 32'h04030201, 16'hFFF8, 1'b0, 1, 32'h00000003};
      vecs[7] = '{2'd3, 3'd5, 32'h87654321, 16'hFFFF, 1'b0, 4, 32'h65432187};

      bus.rd_start  = 1'b0;
      bus.rd_addr   = '0;
      bus.rd_count  = '0;
      bus.bus_ready = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst BusOut", 32'(bus.BusOut), 0);
      check("rst valid", 32'(bus.bus_valid), 0);
      check("rst busy", 32'(bus.busy), 0);
      check("rst done", 32'(bus.done), 0);
`ifdef BUS_PARITY_EN
      check("rst parity", 32'(bus.bus_parity), 0);
`endif
      rstN = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 8; i++)
         run_burst($sformatf("vec%0d", i), vecs[i].addr, vecs[i].cnt, vecs[i].data,
                   vecs[i].pat, vecs[i].poke, vecs[i].n, vecs[i].beats);

      // data in the selected register changes while the beat is stalled
      reg_data      = 32'h0077AA00;
      bus.rd_addr   = 2'd1;
      bus.rd_count  = 3'd2;
      bus.rd_start  = 1'b1;
      bus.bus_ready = 1'b0;
      @(negedge Clk);
      bus.rd_start = 1'b0;
      check("hold first", 32'(bus.BusOut), 32'hAA);
      reg_data[15:8] = 8'h55;
      @(negedge Clk);
      check("hold stall1", 32'(bus.BusOut), 32'hAA);
      @(negedge Clk);
      check("hold stall2", 32'(bus.BusOut), 32'hAA);
      bus.bus_ready = 1'b1;
      @(negedge Clk);
      check("hold next", 32'(bus.BusOut), 32'h77);
      @(negedge Clk);
      check("hold done", 32'(bus.done), 1);
      bus.bus_ready = 1'b0;
      @(negedge Clk);

`ifdef BUS_PARITY_EN
      reg_data      = 32'h0000AB84;
      bus.rd_addr   = 2'd0;
      bus.rd_count  = 3'd2;
      bus.rd_start  = 1'b1;
      @(negedge Clk);
      bus.rd_start = 1'b0;
      check("parity 84", 32'(bus.bus_parity), 0);
      bus.bus_ready = 1'b1;
      @(negedge Clk);
      check("parity AB", 32'(bus.bus_parity), 1);
      @(negedge Clk);
      bus.bus_ready = 1'b0;
      @(negedge Clk);
`endif

      // asynchronous reset in the middle of a stalled burst
      reg_data      = 32'h44332211;
      bus.rd_addr   = 2'd0;
      bus.rd_count  = 3'd4;
      bus.rd_start  = 1'b1;
      @(negedge Clk);
      bus.rd_start = 1'b0;
      check("pre-rst valid", 32'(bus.bus_valid), 1);
      rstN = 1'b0;
      #1;
      check("mid-rst BusOut", 32'(bus.BusOut), 0);
      check("mid-rst valid", 32'(bus.bus_valid), 0);
      check("mid-rst busy", 32'(bus.busy), 0);
      check("mid-rst done", 32'(bus.done), 0);
      @(negedge Clk);
      rstN = 1'b1;
      @(negedge Clk);
      check("post-rst busy", 32'(bus.busy), 0);
      check("post-rst valid", 32'(bus.bus_valid), 0);

      for (int i = 0; i < 24; i++) begin
         r_addr  = 2'($urandom_range(0, 3));
         r_cnt   = 3'($urandom_range(0, 7));
         r_data  = $urandom;
         r_n     = (r_cnt > 3'd4) ? 4 : int'(r_cnt);
         r_beats = '0;
         for (int k = 0; k < r_n; k++)
            r_beats[k*8 +: 8] = model_beat(r_data, int'(r_addr), k);
         run_burst($sformatf("rnd%0d", i), r_addr, r_cnt, r_data, 16'($urandom),
                   1'($urandom_range(0, 1)), r_n, r_beats);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
